// File: rtl/axpy_engine_pkg.sv
// rtl/axpy_engine_pkg.sv - shared constants and FSM encoding for axpy_engine
package axpy_engine_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;

    // Word offsets inside the register region (addresses 0..DEPTH-1)
    localparam int REG_A      = 0;
    localparam int REG_CTRL   = 1;
    localparam int REG_STATUS = 2;
    localparam int REG_LEN    = 3;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    // STATUS read bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    // Address regions, selected by the address bits above the buffer index
    localparam int REGION_REG = 0;
    localparam int REGION_X   = 1;
    localparam int REGION_Y   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/axpy_engine_lane.sv
// rtl/axpy_engine_lane.sv - multiply-add lane: registers a*x and y, presents a*x+y
module axpy_lane
    import axpy_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [IDX_WIDTH-1:0]  in_idx,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    output logic                  out_valid,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic [DATA_WIDTH-1:0] result
);

    logic                  s1_valid;
    logic [IDX_WIDTH-1:0]  s1_idx;
    logic [DATA_WIDTH-1:0] s1_prod;
    logic [DATA_WIDTH-1:0] s1_y;

    // Stage 1: capture index, low half of the product and the addend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_prod  <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_idx   <= in_idx;
            s1_prod  <= a * x;
            s1_y     <= y;
        end
    end

    // Stage 2 is the buffer write in the parent, so the sum is left combinational
    assign out_valid = s1_valid;
    assign out_idx   = s1_idx;
    assign result    = s1_prod + s1_y;

endmodule

// File: rtl/axpy_engine.sv
// rtl/axpy_engine.sv - memory-mapped Y <- A*X + Y vector engine
module axpy_engine
    import axpy_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] dina_i,
    input  logic [ADDR_WIDTH-1:0] addra_i,
    input  logic                  ena_i,
    input  logic                  wea_i,
    output logic [DATA_WIDTH-1:0] douta_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam int RGN_W = ADDR_WIDTH - IDX_W;

    logic [DATA_WIDTH-1:0] a_q;
    logic [LEN_W-1:0]      len_q;
    logic [DATA_WIDTH-1:0] x_mem [DEPTH];
    logic [DATA_WIDTH-1:0] y_mem [DEPTH];
    state_t                state_q, state_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  done_q;
    logic                  done_pulse_q;

    logic                  wr, rd, idle;
    logic [RGN_W-1:0]      region;
    logic [IDX_W-1:0]      offset;
    logic                  in_regs, in_x, in_y;
    logic                  start_cmd, clear_cmd;
    logic                  issue, finish, start_run, start_empty;
    logic [IDX_W-1:0]      issue_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  lane_valid;
    logic [IDX_W-1:0]      lane_idx;
    logic [DATA_WIDTH-1:0] lane_result;

    assign wr      = ena_i & wea_i;
    assign rd      = ena_i & ~wea_i;
    assign idle    = (state_q == ST_IDLE);
    assign region  = addra_i[ADDR_WIDTH-1:IDX_W];
    assign offset  = addra_i[IDX_W-1:0];
    assign in_regs = (region == RGN_W'(REGION_REG));
    assign in_x    = (region == RGN_W'(REGION_X));
    assign in_y    = (region == RGN_W'(REGION_Y));

    assign start_cmd = wr & in_regs & (offset == IDX_W'(REG_CTRL)) & dina_i[CTRL_START];
    assign clear_cmd = wr & in_regs & (offset == IDX_W'(REG_CTRL)) & dina_i[CTRL_CLEAR];

    assign issue_idx = cnt_q[IDX_W-1:0];
    assign busy_o    = ~idle;
    assign done_o    = done_pulse_q;

    axpy_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_W)
    ) u_lane (
        .clk       (CLK),
        .rst_n     (RST),
        .in_valid  (issue),
        .in_idx    (issue_idx),
        .a         (a_q),
        .x         (x_mem[issue_idx]),
        .y         (y_mem[issue_idx]),
        .out_valid (lane_valid),
        .out_idx   (lane_idx),
        .result    (lane_result)
    );

    // Sequencer state and issue counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: issue one index per RUN cycle, then wait for the lane to empty
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        issue       = 1'b0;
        finish      = 1'b0;
        start_run   = 1'b0;
        start_empty = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_cmd) begin
                    if (len_q != '0) begin
                        start_run = 1'b1;
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                    end else begin
                        start_empty = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                issue = 1'b1;
                cnt_d = cnt_q + LEN_W'(1);
                if (cnt_q == len_q - LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!lane_valid) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scalar and length registers, host-writable only while idle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_q   <= '0;
            len_q <= '0;
        end else if (wr && idle && in_regs) begin
            if (offset == IDX_W'(REG_A)) begin
                a_q <= dina_i;
            end
            if (offset == IDX_W'(REG_LEN)) begin
                if (dina_i > DATA_WIDTH'(DEPTH)) begin
                    len_q <= LEN_W'(DEPTH);
                end else begin
                    len_q <= dina_i[LEN_W-1:0];
                end
            end
        end
    end

    // X buffer, host-writable only while idle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                x_mem[i] <= '0;
            end
        end else if (wr && idle && in_x) begin
            x_mem[offset] <= dina_i;
        end
    end

    // Y buffer: host writes while idle, lane writeback while running
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                y_mem[i] <= '0;
            end
        end else begin
            if (wr && idle && in_y) begin
                y_mem[offset] <= dina_i;
            end
            if (lane_valid) begin
                y_mem[lane_idx] <= lane_result;
            end
        end
    end

    // Sticky done flag and one-cycle completion pulse; a start beats a clear
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= finish | start_empty;
            if (finish || start_empty) begin
                done_q <= 1'b1;
            end else if (start_run || clear_cmd) begin
                done_q <= 1'b0;
            end
        end
    end

    // Read mux; a Y read that meets the writeback of the same index sees the new value
    always_comb begin
        rd_data = '0;
        if (in_regs) begin
            if (offset == IDX_W'(REG_A)) begin
                rd_data = a_q;
            end else if (offset == IDX_W'(REG_STATUS)) begin
                rd_data[STAT_BUSY] = ~idle;
                rd_data[STAT_DONE] = done_q;
            end else if (offset == IDX_W'(REG_LEN)) begin
                rd_data = DATA_WIDTH'(len_q);
            end
        end else if (in_x) begin
            rd_data = x_mem[offset];
        end else if (in_y) begin
            if (lane_valid && (lane_idx == offset)) begin
                rd_data = lane_result;
            end else begin
                rd_data = y_mem[offset];
            end
        end
    end

    // Registered read data, zero on any cycle without a read
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            douta_o <= '0;
        end else if (rd) begin
            douta_o <= rd_data;
        end else begin
            douta_o <= '0;
        end
    end

endmodule

// File: tb/tb_axpy_engine.sv
// tb/tb_axpy_engine.sv - scoreboard bench for axpy_engine
module tb_axpy_engine;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] douta;
    logic          busy;
    logic          done;

    axpy_engine #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .dina_i  (din),
        .addra_i (addr),
        .ena_i   (ena),
        .wea_i   (wea),
        .douta_o (douta),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q [$];
    string         name_q [$];
    logic          rd_seen = 1'b0;

    logic [DW-1:0] m_a;
    int            m_len;
    logic [DW-1:0] m_x [DEPTH];
    logic [DW-1:0] m_y [DEPTH];
    logic          m_done;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: a read sampled at a rising edge is compared at the following falling edge
    always @(posedge CLK) rd_seen <= ena & ~wea;

    always @(negedge CLK) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check(name_q.pop_front(), douta, exp_q.pop_front());
            end
        end else begin
            check("douta_idle", douta, '0);
        end
    end

    task automatic model_reset();
        m_a    = '0;
        m_len  = 0;
        m_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m_x[i] = '0;
            m_y[i] = '0;
        end
    endtask

    function automatic logic [DW-1:0] model_read(input int a);
        if (a == 0) return m_a;
        if (a == 2) return {30'd0, m_done, 1'b0};
        if (a == 3) return 32'(m_len);
        if (a >= DEPTH && a < 2 * DEPTH) return m_x[a - DEPTH];
        if (a >= 2 * DEPTH && a < 3 * DEPTH) return m_y[a - 2 * DEPTH];
        return '0;
    endfunction

    // Bus tasks are entered at a falling edge and return at the next one
    task automatic host_write(input int a, input logic [DW-1:0] d);
        ena = 1'b1; wea = 1'b1; addr = AW'(a); din = d;
        @(negedge CLK);
        ena = 1'b0; wea = 1'b0;
        if (a == 0) m_a = d;
        else if (a == 3) m_len = (d > DEPTH) ? DEPTH : int'(d);
        else if (a >= DEPTH && a < 2 * DEPTH) m_x[a - DEPTH] = d;
        else if (a >= 2 * DEPTH && a < 3 * DEPTH) m_y[a - 2 * DEPTH] = d;
    endtask

    task automatic host_read(input int a, input string name);
        exp_q.push_back(model_read(a));
        name_q.push_back(name);
        ena = 1'b1; wea = 1'b0; addr = AW'(a);
        @(negedge CLK);
        ena = 1'b0;
    endtask

    task automatic clear_done();
        host_write(1, 32'h2);
        m_done = 1'b0;
    endtask

    task automatic read_all_y(input string tag);
        for (int i = 0; i < DEPTH; i++) host_read(2 * DEPTH + i, $sformatf("%s_y%0d", tag, i));
    endtask

    // Start a run, watch busy/done, optionally poke the bus while busy or pull reset
    task automatic do_start(input string tag, input bit inject, input int rst_k);
        int l;
        int busy_cnt;
        int pulses;
        int pulse_k;
        l = m_len;
        busy_cnt = 0;
        pulses = 0;
        pulse_k = -1;
        ena = 1'b1; wea = 1'b1; addr = AW'(1); din = 32'h1;
        @(negedge CLK);
        ena = 1'b0; wea = 1'b0;
        for (int k = 0; k < l + 8; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                pulses++;
                if (pulse_k < 0) pulse_k = k;
            end
            ena = 1'b0; wea = 1'b0;
            if (inject && k == 2) begin
                ena = 1'b1; wea = 1'b1; addr = AW'(2 * DEPTH); din = 32'h55;
            end else if (inject && k == 3) begin
                ena = 1'b1; wea = 1'b1; addr = AW'(1); din = 32'h1;
            end
            if (rst_k >= 0 && k == rst_k) RST = 1'b0;
            if (rst_k >= 0 && k == rst_k + 2) RST = 1'b1;
            @(negedge CLK);
        end
        ena = 1'b0; wea = 1'b0;
        if (rst_k < 0) begin
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'((l == 0) ? 0 : l + 2));
            check({tag, "_done_pulses"}, 32'(pulses), 32'd1);
            check({tag, "_done_when"}, 32'(pulse_k), 32'((l == 0) ? 0 : l + 2));
            for (int i = 0; i < l; i++) m_y[i] = m_a * m_x[i] + m_y[i];
            m_done = 1'b1;
        end else begin
            check({tag, "_rst_pulses"}, 32'(pulses), 32'd0);
            check({tag, "_rst_busy"}, 32'(busy), 32'd0);
            check({tag, "_rst_done"}, 32'(done), 32'd0);
            model_reset();
        end
    endtask

    task automatic random_run(input string tag);
        host_write(0, $urandom());
        for (int i = 0; i < DEPTH; i++) begin
            host_write(DEPTH + i, $urandom());
            host_write(2 * DEPTH + i, $urandom());
        end
        host_write(3, 32'($urandom_range(0, 24)));
        host_read(3, {tag, "_len"});
        do_start(tag, 1'b0, -1);
        read_all_y(tag);
        host_read(DEPTH + int'($urandom_range(0, DEPTH - 1)), {tag, "_x"});
        host_read(2, {tag, "_status"});
        if ($urandom_range(0, 1) == 1) begin
            clear_done();
            host_read(2, {tag, "_status_clr"});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        RST = 1'b0; ena = 1'b0; wea = 1'b0; addr = '0; din = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        host_read(0, "rst_a");
        host_read(3, "rst_len");
        host_read(2, "rst_status");
        host_read(1, "rst_ctrl");
        host_read(DEPTH, "rst_x0");
        host_read(2 * DEPTH, "rst_y0");
        host_read(5, "unmapped_reg");
        host_read(60, "unmapped_high");

        host_write(0, 32'd3);
        for (int i = 0; i < DEPTH; i++) begin
            host_write(DEPTH + i, 32'(i));
            host_write(2 * DEPTH + i, 32'd10);
        end
        host_write(3, 32'd16);
        do_start("full", 1'b0, -1);
        read_all_y("full");
        host_read(2, "full_status");

        host_write(0, 32'hFFFF_FFFF);
        host_write(DEPTH, 32'd2);
        host_write(2 * DEPTH, 32'd5);
        host_write(3, 32'd1);
        do_start("wrap", 1'b0, -1);
        host_read(2 * DEPTH, "wrap_y0");
        host_read(2 * DEPTH + 1, "wrap_y1");

        host_write(3, 32'd16);
        do_start("inject", 1'b1, -1);
        read_all_y("inject");
        host_write(3, 32'd40);
        host_read(3, "len_clamp");

        host_write(3, 32'd0);
        clear_done();
        do_start("len0", 1'b0, -1);
        host_read(2, "len0_status");
        clear_done();
        host_read(2, "clr_status");

        for (int r = 0; r < 6; r++) random_run($sformatf("rnd%0d", r));

        host_write(0, 32'd7);
        for (int i = 0; i < DEPTH; i++) host_write(DEPTH + i, 32'(i + 1));
        host_write(3, 32'd16);
        do_start("abort", 1'b0, 5);
        host_read(0, "abort_a");
        host_read(3, "abort_len");
        host_read(2, "abort_status");
        host_read(DEPTH, "abort_x0");
        read_all_y("abort");

        random_run("rerun");

        repeat (3) @(negedge CLK);
        check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
